// File: rtl/text_mem_sched_pkg.sv
// Shared constants and state encoding for the text RAM scheduler.
package text_mem_sched_pkg;

  localparam int H_DISP          = 1280;
  localparam int V_DISP          = 1024;
  localparam int CHAR_ADDR_WIDTH = 15;

  function automatic int cells_for(input int h, input int v);
    return (h / 8) * (v / 8);
  endfunction

  localparam int CELLS = cells_for(H_DISP, V_DISP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2,
    ST_CLEAR   = 2'd3
  } state_e;

endpackage

// File: rtl/text_mem_sched_if.sv
// Bundle of the display, CPU, clear-engine and RAM signals around the scheduler.
interface text_mem_sched_if;
  import text_mem_sched_pkg::*;

  // Handshake: cpu_req is held with cpu_we/cpu_addr/cpu_wdata stable until the
  // single-cycle cpu_ack; disp_en and clr_start are unconditioned (no backpressure).
  logic                       disp_en;
  logic [CHAR_ADDR_WIDTH-1:0] disp_addr;
  logic [7:0]                 disp_char;

  logic                       cpu_req;
  logic                       cpu_we;
  logic [CHAR_ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]                 cpu_wdata;
  logic                       cpu_ack;
  logic [7:0]                 cpu_rdata;

  logic                       clr_start;
  logic [7:0]                 fill_char;
  logic                       clr_busy;
  logic                       clr_done;

  logic [CHAR_ADDR_WIDTH-1:0] mem_addr;
  logic                       mem_we;
  logic [7:0]                 mem_din;
  logic [7:0]                 mem_dout;

  modport master (
    output disp_en, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           clr_start, fill_char, mem_dout,
    input  disp_char, cpu_ack, cpu_rdata, clr_busy, clr_done,
           mem_addr, mem_we, mem_din
  );

  modport slave (
    input  disp_en, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           clr_start, fill_char, mem_dout,
    output disp_char, cpu_ack, cpu_rdata, clr_busy, clr_done,
           mem_addr, mem_we, mem_din
  );

endinterface

// File: rtl/text_mem_sched.sv
// Arbitrates the single-port text RAM: display always wins, then the clear
// engine, then the CPU port; display data sees a fixed 1-cycle latency.
module text_mem_sched
  import text_mem_sched_pkg::*;
#(
  parameter int h_disp = H_DISP,
  parameter int v_disp = V_DISP
) (
  input  logic       clk,
  input  logic       reset,
  text_mem_sched_if.slave bus,
  output state_e     state_o
);

  localparam int AW = CHAR_ADDR_WIDTH;
  localparam int NUM_CELLS = cells_for(h_disp, v_disp);
  localparam logic [AW-1:0] CELLS_A   = AW'(NUM_CELLS);
  localparam logic [AW-1:0] LAST_CELL = AW'(NUM_CELLS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic          rd_oob_q, rd_oob_d;
  logic [7:0]    disp_hold_q;
  logic          last_disp_q;
  logic          cpu_in_range;

  assign cpu_in_range  = (bus.cpu_addr < CELLS_A);
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.disp_char = last_disp_q ? bus.mem_dout : disp_hold_q;
  assign state_o       = state_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    rd_oob_d    = rd_oob_q;
    bus.mem_addr = bus.disp_addr;
    bus.mem_we   = 1'b0;
    bus.mem_din  = bus.cpu_wdata;

    case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_d    = ST_CLEAR;
          clr_busy_d = 1'b1;
          clr_cnt_d  = '0;
        end else if (bus.cpu_req && !bus.disp_en) begin
          bus.mem_addr = bus.cpu_addr;
          if (bus.cpu_we) begin
            // Out-of-range writes are dropped but acked like normal writes.
            bus.mem_we = cpu_in_range;
            cpu_ack_d  = 1'b1;
            state_d    = ST_ACK;
          end else begin
            rd_oob_d = !cpu_in_range;
            state_d  = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // mem_dout here belongs to the grant-cycle address, whoever owns the RAM now.
        cpu_rdata_d = rd_oob_q ? 8'h00 : bus.mem_dout;
        cpu_ack_d   = 1'b1;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (!bus.disp_en) begin
          bus.mem_addr = clr_cnt_q;
          bus.mem_we   = 1'b1;
          bus.mem_din  = bus.fill_char;
          if (clr_cnt_q == LAST_CELL) begin
            state_d    = ST_IDLE;
            clr_busy_d = 1'b0;
            clr_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No RAM write may slip through while reset is asserted (aborted clears).
    if (reset) bus.mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      rd_oob_q    <= 1'b0;
      disp_hold_q <= 8'h00;
      last_disp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      rd_oob_q    <= rd_oob_d;
      last_disp_q <= bus.disp_en;
      if (last_disp_q) disp_hold_q <= bus.mem_dout;
    end
  end

endmodule

// File: tb/tb_text_mem_sched.sv
// Directed bench for text_mem_sched with a behavioural 1-cycle-latency text RAM.
module tb_text_mem_sched;
  import text_mem_sched_pkg::*;

  logic   clk;
  logic   reset;
  logic   load_pat;
  state_e state_o;
  int     checks;
  int     failures;

  text_mem_sched_if bus();

  text_mem_sched dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // RAM model: read-first, registered output; out-of-range reads return junk.
  logic [7:0] ram [CELLS];
  always @(posedge clk) begin
    if (load_pat) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= pat(i);
    end else if (bus.mem_we && (int'(bus.mem_addr) < CELLS)) begin
      ram[bus.mem_addr] <= bus.mem_din;
    end
    bus.mem_dout <= (int'(bus.mem_addr) < CELLS) ? ram[bus.mem_addr] : 8'hEE;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc;
    int stalls;
    int ack_seen;
    int bad;
    int no_grant;
    logic got_done;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    load_pat = 1'b1;
    bus.disp_en = 1'b0;
    bus.disp_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = 8'h00;
    bus.clr_start = 1'b0;
    bus.fill_char = 8'h00;

    // ---------------- reset ----------------
    step();
    load_pat = 1'b0;
    step();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_ack", bus.cpu_ack, 1'b0);
    chk("rst_rdata", bus.cpu_rdata, 8'h00);
    chk("rst_busy", bus.clr_busy, 1'b0);
    chk("rst_done", bus.clr_done, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_disp_char", bus.disp_char, 8'h00);
    reset = 1'b0;
    step();

    // ---------------- CPU write then read of cell 100 ----------------
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'd100; bus.cpu_wdata = 8'h41;
    #1;
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 15'd100);
    chk("wr_mem_din", bus.mem_din, 8'h41);
    chk("wr_ack_T", bus.cpu_ack, 1'b0);
    step();
    chk("wr_ack_T1", bus.cpu_ack, 1'b1);
    chk("wr_state_ack", state_o, ST_ACK);
    bus.cpu_req = 1'b0;
    step();
    chk("wr_ack_T2", bus.cpu_ack, 1'b0);
    chk("wr_ram100", ram[100], 8'h41);

    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd100;
    step();
    chk("rd_ack_G1", bus.cpu_ack, 1'b0);
    chk("rd_state_wait", state_o, ST_RD_WAIT);
    step();
    chk("rd_ack_G2", bus.cpu_ack, 1'b1);
    chk("rd_data100", bus.cpu_rdata, 8'h41);
    bus.cpu_req = 1'b0;
    step();
    chk("rd_ack_G3", bus.cpu_ack, 1'b0);
    chk("rd_data_held", bus.cpu_rdata, 8'h41);

    // ---------------- display priority over a pending CPU read ----------------
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd5;
    bus.disp_en = 1'b1;
    no_grant = 1;
    for (int i = 0; i < 20; i++) begin
      bus.disp_addr = 15'(10 + i);
      #1;
      if (bus.mem_addr !== 15'(10 + i) || bus.mem_we !== 1'b0 || state_o !== ST_IDLE)
        no_grant = 0;
      if (i > 0) chk("prio_disp_char", bus.disp_char, pat(10 + i - 1));
      step();
    end
    chk("prio_no_grant", no_grant, 1);
    bus.disp_en = 1'b0;
    #1;
    chk("prio_grant_addr", bus.mem_addr, 15'd5);
    chk("prio_last_disp", bus.disp_char, pat(29));
    step();
    chk("prio_state_wait", state_o, ST_RD_WAIT);
    chk("prio_hold_char", bus.disp_char, pat(29));
    step();
    chk("prio_ack", bus.cpu_ack, 1'b1);
    chk("prio_rdata", bus.cpu_rdata, pat(5));
    bus.cpu_req = 1'b0;
    step();

    // ---------------- CPU read interleaved with a display fetch ----------------
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd200;
    #1;
    chk("ilv_grant_addr", bus.mem_addr, 15'd200);
    step();
    bus.disp_en = 1'b1; bus.disp_addr = 15'd7;
    step();
    bus.disp_en = 1'b0; bus.disp_addr = 15'd9;
    #1;
    chk("ilv_ack", bus.cpu_ack, 1'b1);
    chk("ilv_rdata", bus.cpu_rdata, pat(200));
    chk("ilv_disp_T2", bus.disp_char, pat(7));
    bus.cpu_req = 1'b0;
    step();
    chk("ilv_disp_T3", bus.disp_char, pat(7));
    chk("ilv_state_idle", state_o, ST_IDLE);

    // ---------------- out-of-range CPU accesses ----------------
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'd20480; bus.cpu_wdata = 8'hFF;
    #1;
    chk("oob_wr_no_we", bus.mem_we, 1'b0);
    step();
    chk("oob_wr_ack", bus.cpu_ack, 1'b1);
    bus.cpu_req = 1'b0;
    step();
    chk("oob_ram0", ram[0], pat(0));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd20480;
    step();
    chk("oob_rd_ack_G1", bus.cpu_ack, 1'b0);
    step();
    chk("oob_rd_ack_G2", bus.cpu_ack, 1'b1);
    chk("oob_rd_data", bus.cpu_rdata, 8'h00);
    bus.cpu_req = 1'b0;
    step();

    // ---------------- clr_start during RD_WAIT is ignored ----------------
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'd3;
    step();
    bus.clr_start = 1'b1;
    #1;
    chk("ign_state_wait", state_o, ST_RD_WAIT);
    step();
    bus.clr_start = 1'b0;
    chk("ign_busy_T2", bus.clr_busy, 1'b0);
    chk("ign_state_ack", state_o, ST_ACK);
    chk("ign_rdata", bus.cpu_rdata, pat(3));
    bus.cpu_req = 1'b0;
    step();
    chk("ign_state_idle", state_o, ST_IDLE);
    chk("ign_busy_T3", bus.clr_busy, 1'b0);

    // ---------------- clear with display gaps and a CPU write waiting ----------------
    bus.fill_char = 8'h20; bus.disp_addr = 15'd0; bus.disp_en = 1'b0;
    bus.clr_start = 1'b1;
    #1;
    chk("clr_start_no_we", bus.mem_we, 1'b0);
    step();
    bus.clr_start = 1'b0;
    chk("clr_busy", bus.clr_busy, 1'b1);
    chk("clr_state", state_o, ST_CLEAR);
    cyc = 1; stalls = 0; ack_seen = 0; got_done = 1'b0;
    while (!got_done && cyc < 60000) begin
      cyc++;
      bus.disp_en = cyc[0];
      if (bus.disp_en) stalls++;
      if (cyc == 100) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'd50; bus.cpu_wdata = 8'h77;
      end
      step();
      if (bus.cpu_ack) ack_seen++;
      if (bus.clr_done) got_done = 1'b1;
    end
    chk("clr_done_seen", got_done, 1'b1);
    bus.disp_en = 1'b0;
    #1;
    chk("clr_busy_end", bus.clr_busy, 1'b0);
    chk("clr_state_idle", state_o, ST_IDLE);
    chk("clr_cycles", cyc, CELLS + stalls + 1);
    chk("clr_no_cpu_ack", ack_seen, 0);
    chk("clr_cpu_we", bus.mem_we, 1'b1);
    chk("clr_cpu_addr", bus.mem_addr, 15'd50);
    step();
    chk("clr_cpu_ack", bus.cpu_ack, 1'b1);
    chk("clr_done_pulse", bus.clr_done, 1'b0);
    bus.cpu_req = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < CELLS; i++) if (i != 50 && ram[i] !== 8'h20) bad++;
    chk("clr_fill_cells", bad, 0);
    chk("clr_cpu_cell50", ram[50], 8'h77);

    // ---------------- reset in the middle of a clear ----------------
    bus.fill_char = 8'hAA;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (1000) step();
    chk("mid_addr1000", bus.mem_addr, 15'd1000);
    reset = 1'b1;
    #1;
    chk("mid_rst_no_we", bus.mem_we, 1'b0);
    step();
    chk("mid_busy", bus.clr_busy, 1'b0);
    chk("mid_state", state_o, ST_IDLE);
    chk("mid_done", bus.clr_done, 1'b0);
    reset = 1'b0;
    step();
    chk("mid_done_after", bus.clr_done, 1'b0);
    chk("mid_ram999", ram[999], 8'hAA);
    chk("mid_ram1000", ram[1000], 8'h20);
    bad = 0;
    for (int i = 1000; i < CELLS; i++) if (ram[i] !== 8'h20) bad++;
    chk("mid_upper_cells", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
